// File: rtl/vd6_fsm.sv
// Run-of-zeros detector on serial input w: q is high once w has been 0
// for two or more consecutive sampled edges.
//
// state | meaning
// A     | reset / idle, no run history
// B     | exactly one 0 seen since the last 1 or reset
// C     | two or more consecutive 0s seen (q=1)
// F     | last sampled w was 1
module vd6_fsm (
  input  logic clk,
  input  logic Reset,
  input  logic w,
  output logic q
);

  typedef enum logic [1:0] {
    A = 2'b00,
    B = 2'b01,
    C = 2'b10,
    F = 2'b11
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (Reset) state <= A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = A;
    case (state)
      A:       state_nxt = w ? F : B;
      B:       state_nxt = w ? F : C;
      C:       state_nxt = w ? F : C;
      F:       state_nxt = w ? F : B;
      default: state_nxt = A;
    endcase
  end

  // Moore output decoded from the register only; no path from w
  assign q = (state == C);

endmodule

// File: tb/tb_vd6_fsm.sv
// Self-checking bench for vd6_fsm: a zero-run-length model pushes expected q
// into a queue at drive time; the value is popped and compared after the edge.
module tb_vd6_fsm;

  logic clk;
  logic Reset;
  logic w;
  logic q;

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  int zero_run = 0;

  vd6_fsm dut (
    .clk  (clk),
    .Reset(Reset),
    .w    (w),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: q=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, push the model's post-edge q, then compare after the edge
  task automatic step(input string tag, input logic r, input logic wv);
    bit e;
    @(negedge clk);
    Reset = r;
    w     = wv;
    if (r)       zero_run = 0;
    else if (wv) zero_run = 0;
    else         zero_run = (zero_run < 2) ? zero_run + 1 : 2;
    exp_q.push_back(zero_run >= 2);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, q, e);
    end
  endtask

  initial begin
    Reset = 1'b1;
    w     = 1'b0;

    for (int i = 0; i < 10; i++) step("reset_hold", 1'b1, 1'b0);

    step("zeros_b", 1'b0, 1'b0);
    step("zeros_c", 1'b0, 1'b0);
    step("zeros_c2", 1'b0, 1'b0);
    step("zeros_c3", 1'b0, 1'b0);

    step("c_to_f", 1'b0, 1'b1);
    step("f_to_f", 1'b0, 1'b1);
    step("f_to_b", 1'b0, 1'b0);
    step("b_to_f", 1'b0, 1'b1);
    step("f_to_b2", 1'b0, 1'b0);

    step("to_a", 1'b1, 1'b0);
    step("a_to_f", 1'b0, 1'b1);
    step("f_to_b3", 1'b0, 1'b0);
    step("b_to_f2", 1'b0, 1'b1);
    step("f_to_b4", 1'b0, 1'b0);
    step("b_to_c", 1'b0, 1'b0);

    step("rst_in_c", 1'b1, 1'b0);
    step("post_rst_b", 1'b0, 1'b0);
    step("post_rst_c", 1'b0, 1'b0);

    step("to_f", 1'b0, 1'b1);
    step("rst_prio_f", 1'b1, 1'b1);
    step("after_prio", 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++)
      step("random", ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
